// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared types and helpers for the FFT address sequencer.
//   - fft_seq_state_t : sequencer FSM state encoding
//   - bf_addr()       : {A, B, k} for butterfly j of stage s in an
//                       n-point-log2 radix-2 DIT FFT
//   - FFT_PTS/FFT_BFLY: point and butterfly counts for the default size
package fft_pkg;

  localparam int FFT_N_DEFAULT = 10;
  localparam int FFT_PTS       = 2 ** FFT_N_DEFAULT;
  localparam int FFT_BFLY      = FFT_PTS / 2;

  // Widest transform the address helper supports; callers truncate.
  localparam int FFT_N_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } fft_seq_state_t;

  typedef struct packed {
    logic [FFT_N_MAX-1:0] a;
    logic [FFT_N_MAX-1:0] b;
    logic [FFT_N_MAX-1:0] k;
  } bf_addr_t;

  // Butterfly j of stage s: pairs are h = 2^s apart, groups of 2h points.
  // The twiddle index is scaled so that every stage indexes one shared
  // quarter/half-wave table of 2^(n-1) entries.
  function automatic bf_addr_t bf_addr(input int n, input int s, input int j);
    logic [31:0] h;
    logic [31:0] grp;
    logic [31:0] pos;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] k;
    bf_addr_t    r;
    h     = 32'd1 << s;
    grp   = 32'(j) >> s;
    pos   = 32'(j) & (h - 32'd1);
    a     = (grp << (s + 1)) | pos;
    b     = a + h;
    k     = (pos << (n - 1 - s)) & ((32'd1 << (n - 1)) - 32'd1);
    r.a   = a[FFT_N_MAX-1:0];
    r.b   = b[FFT_N_MAX-1:0];
    r.k   = k[FFT_N_MAX-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line
//   Fixed-depth shift register with synchronous clear. Used to turn the
//   read strobe/address into the matching write strobe/address after the
//   butterfly latency.
//   Ports:
//     clk   - clock
//     clear - synchronous clear of every tap (active-high)
//     din   - data entering the line
//     dout  - data that entered DEPTH cycles earlier
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (clear) q_reg <= '0;
          else       q_reg <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (clear) q_reg <= '0;
          else       q_reg <= g_tap[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_tap[DEPTH-1].q_reg;

endmodule

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer
//   Walks every stage and butterfly of an in-place radix-2 DIT FFT of
//   2^FFT_N points, issuing data-RAM reads (A then B), the twiddle request
//   for the twiddle ROM bridge, and the delayed data-RAM writes. Between
//   stages it idles BF_LAT cycles so the last write of a stage lands before
//   the first read of the next one.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     start        - one-cycle request to begin a transform (ignored when busy)
//     busy         - transform in progress (RUN/DRAIN)
//     done         - one-cycle completion pulse
//     stage        - current stage index
//     rd_en/rd_addr- data-RAM read strobe/address
//     tact_rom     - twiddle request active (same as rd_en)
//     evenOdd      - 0 on the A read, 1 on the B read
//     ta_rom       - twiddle index k, held over both reads of a butterfly
//     wr_en/wr_addr- data-RAM write strobe/address, BF_LAT after the read
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N  = 10,
  parameter int BF_LAT = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(FFT_N)-1:0]   stage,
  output logic                       rd_en,
  output logic [FFT_N-1:0]           rd_addr,
  output logic                       tact_rom,
  output logic                       evenOdd,
  output logic [FFT_N-2:0]           ta_rom,
  output logic                       wr_en,
  output logic [FFT_N-1:0]           wr_addr
);

  localparam int STAGE_W = $clog2(FFT_N);
  localparam int J_W     = FFT_N - 1;
  localparam int DC_W    = $clog2(BF_LAT);

  fft_seq_state_t     state_reg;
  logic [STAGE_W-1:0] s_reg;
  logic [J_W-1:0]     j_reg;
  logic               phase_reg;      // 0: A read issued, 1: B read issued
  logic [DC_W-1:0]    drain_cnt_reg;

  logic [J_W-1:0]     j_inc;
  logic               j_last;
  logic               s_last;
  logic               drain_last;
  bf_addr_t           bf_cur;
  bf_addr_t           bf_nxt;
  logic               unused_bf_bits;

  assign j_inc      = j_reg + 1'b1;
  assign j_last     = (j_reg == '1);
  assign s_last     = (s_reg == STAGE_W'(FFT_N - 1));
  assign drain_last = (drain_cnt_reg == DC_W'(BF_LAT - 1));

  // Current butterfly supplies the B address; the next one supplies the
  // following A address and twiddle index.
  assign bf_cur = bf_addr(FFT_N, int'(s_reg), int'(j_reg));
  assign bf_nxt = bf_addr(FFT_N, int'(s_reg), int'(j_inc));

  // The helper returns full-width fields; only the low bits are used here.
  assign unused_bf_bits = ^{bf_cur, bf_nxt};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      s_reg         <= '0;
      j_reg         <= '0;
      phase_reg     <= 1'b0;
      drain_cnt_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      stage         <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      tact_rom      <= 1'b0;
      evenOdd       <= 1'b0;
      ta_rom        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Butterfly 0 of any stage is A=0, k=0.
            state_reg <= ST_RUN;
            busy      <= 1'b1;
            s_reg     <= '0;
            j_reg     <= '0;
            phase_reg <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b1;
            tact_rom  <= 1'b1;
            evenOdd   <= 1'b0;
            rd_addr   <= '0;
            ta_rom    <= '0;
          end
        end

        ST_RUN: begin
          if (!phase_reg) begin
            phase_reg <= 1'b1;
            evenOdd   <= 1'b1;
            rd_addr   <= bf_cur.b[FFT_N-1:0];
            ta_rom    <= bf_cur.k[FFT_N-2:0];
          end else if (!j_last) begin
            j_reg     <= j_inc;
            phase_reg <= 1'b0;
            evenOdd   <= 1'b0;
            rd_addr   <= bf_nxt.a[FFT_N-1:0];
            ta_rom    <= bf_nxt.k[FFT_N-2:0];
          end else begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            rd_en         <= 1'b0;
            tact_rom      <= 1'b0;
            evenOdd       <= 1'b0;
            rd_addr       <= '0;
            ta_rom        <= '0;
          end
        end

        ST_DRAIN: begin
          if (drain_last) begin
            if (s_last) begin
              state_reg <= ST_FIN;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              s_reg     <= s_reg + 1'b1;
              stage     <= s_reg + 1'b1;
              j_reg     <= '0;
              phase_reg <= 1'b0;
              rd_en     <= 1'b1;
              tact_rom  <= 1'b1;
              evenOdd   <= 1'b0;
              rd_addr   <= '0;
              ta_rom    <= '0;
            end
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end

        ST_FIN: begin
          state_reg <= ST_IDLE;
          stage     <= '0;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // rd_addr is forced to 0 whenever rd_en is low, so the delayed address
  // is 0 whenever no write is issued.
  fft_delay_line #(
    .WIDTH(FFT_N + 1),
    .DEPTH(BF_LAT)
  ) u_wr_delay (
    .clk  (clk),
    .clear(reset),
    .din  ({rd_en, rd_addr}),
    .dout ({wr_en, wr_addr})
  );

endmodule

// File: doc/fft_addr_sequencer.md
# fft_addr_sequencer

Control sequencer for the in-place radix-2 DIT FFT of 2^FFT_N points. It walks every stage and butterfly and drives the data-RAM read/write addresses and the twiddle request (`tact_rom`, `ta_rom`, `evenOdd`) consumed by `twiddleFactorRomBridge`. It sits directly upstream of that bridge and beside the butterfly datapath. It also enforces the stage-to-stage drain that in-place operation needs.

## Interface
Parameters:
- `FFT_N`, 10, log2 of transform size; stages = FFT_N.
- `BF_LAT`, 6, cycles from a read issue to the matching write issue (butterfly plus twiddle path). Must be ≥ 4.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a transform
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at completion
- `stage`  out  $clog2(FFT_N)  current stage index, for downstream scaling
- `rd_en`  out  1  data-RAM read strobe
- `rd_addr`  out  FFT_N  data-RAM read address
- `tact_rom`  out  1  twiddle request active; equals `rd_en`
- `evenOdd`  out  1  0 on the A-read cycle, 1 on the B-read cycle
- `ta_rom`  out  FFT_N-1  twiddle index k, meaning W^k; held for both cycles of a butterfly
- `wr_en`  out  1  data-RAM write strobe
- `wr_addr`  out  FFT_N  data-RAM write address

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: `start` moves to RUN, with s=0 and j=0.
  - RUN: issues one read per cycle.
  - DRAIN: counts BF_LAT cycles, then goes to RUN with the next stage. After the last stage it goes to FIN instead.
  - FIN: pulses `done` for one cycle, then returns to IDLE.
- Stage s, butterfly j = 0 .. 2^(FFT_N-1)-1:
  - h = 2^s; group = j>>s; pos = j & (h-1).
  - A = group·2h + pos; B = A + h (FFT_N-bit, no overflow).
  - k = pos << (FFT_N-1-s), truncated to FFT_N-1 bits.
- Each butterfly takes 2 RUN cycles:
  - cycle 0: `rd_addr`=A, `evenOdd`=0.
  - cycle 1: `rd_addr`=B, `evenOdd`=1.
  - Both cycles: `rd_en`=`tact_rom`=1 and `ta_rom`=k.
- Write path: a BF_LAT-deep delay line carries {valid, address}. `wr_en`/`wr_addr` equal the `rd_en`/`rd_addr` issued BF_LAT cycles earlier, so A is written then B.
- `start` is ignored while `busy`, including during FIN.
- Reset takes effect at any time:
  - next state is IDLE;
  - the delay line is cleared, so no stale `wr_en` appears after reset;
  - all outputs are 0.

## Timing
- Reset value is 0 for every output.
- `start` accepted in cycle t:
  - first `rd_en` in cycle t+1;
  - `busy` rises in cycle t+1.
- Per stage:
  - 2^FFT_N RUN cycles, followed by BF_LAT DRAIN cycles;
  - the next stage's first read lands 1 cycle after the previous stage's last write, so there is no read-after-write hazard.
- `done` timing:
  - pulses in cycle t+1+FFT_N·(2^FFT_N+BF_LAT);
  - `busy` falls in the same cycle.
- `stage` updates on the first RUN cycle of each stage and holds through its DRAIN.
- Twiddle data appears at the bridge output 3 cycles after the `evenOdd`=0 cycle. BF_LAT must absorb this (hence BF_LAT ≥ 4).
- A `start` pulse coincident with `reset` is dropped.

## Structure
- Package `fft_pkg` holds:
  - FSM state enum `fft_seq_state_t`;
  - function `bf_addr(s, j)` returning {A, B, k};
  - localparams `FFT_PTS = 2**FFT_N` and `FFT_BFLY = FFT_PTS/2`.
- Sub-module `fft_delay_line`: parameterised width × depth shift register with synchronous clear. It carries {wr_en, wr_addr}.
- The counters j, s, sub-cycle bit and drain count live in `fft_addr_sequencer`.

## Test plan
- **Reset**: hold reset 3 cycles → all outputs 0, no `wr_en`. Pulse `start` with reset high → stays IDLE.
- **Stage 0 addresses** (FFT_N=3, BF_LAT=4), start at t:
  - `rd_addr` sequence 0,1,2,3,4,5,6,7, with `evenOdd` 0,1,0,1,…;
  - `ta_rom`=0 throughout.
- **Stage 2 addresses** (FFT_N=3):
  - `rd_addr` sequence 0,4,1,5,2,6,3,7;
  - `ta_rom` 0,0,1,1,2,2,3,3.
- **Write alignment and total length**:
  - every `wr_addr` equals `rd_addr` from 4 cycles earlier;
  - no read falls in the same cycle as, or before, the previous stage's last write;
  - `done` pulses at t+1+3·(8+4)=t+37.
- **Busy and restart**:
  - `start` reasserted mid-stage-1 → ignored, sequence unchanged;
  - `start` after `done` → a new identical run.
- **Reset mid-operation**: reset during stage 1 DRAIN → `wr_en` low from the next cycle; IDLE; a new `start` restarts at stage 0.
